// File: rtl/structure1_fc1_acc.sv
// FC1 neuron engine: bias fetch, MAC over N_IN operand pairs,
// then ReLU with requantization to 0..127, one result per neuron.
module structure1_fc1_acc #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 128,
  parameter int FRAC  = 4,
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] w_in,
  output logic       bias_en,
  input  logic [7:0] bias_in,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_idx,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    BIAS_REQ,
    BIAS_WAIT,
    ACC,
    OUT,
    DONE
  } state_t;

  localparam logic [7:0] K_LAST = 8'(N_IN - 1);
  localparam logic [7:0] N_LAST = 8'(N_OUT - 1);

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [15:0]      prod;
  logic [7:0] k_q, k_d;
  logic [7:0] n_q, n_d;
  logic [7:0] sat;

  logic       in_ready_q, bias_en_q, out_valid_q, done_q;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] out_idx_q, out_idx_d;

  assign prod = $signed(x_in) * $signed(w_in);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        n_d = 8'd0;
        if (start) state_d = BIAS_REQ;
      end
      BIAS_REQ: state_d = BIAS_WAIT;
      BIAS_WAIT: begin
        acc_d = {{(ACC_W-8){bias_in[7]}}, bias_in}
                <<< FRAC;
        k_d = 8'd0;
        state_d = ACC;
      end
      ACC: begin
        if (in_valid) begin
          acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
          k_d = k_q + 8'd1;
          if (k_q == K_LAST) state_d = OUT;
        end
      end
      OUT: begin
        if (n_q == N_LAST) begin
          state_d = DONE;
        end else begin
          n_d = n_q + 8'd1;
          state_d = BIAS_REQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requantize the value that will be final on entry to OUT.
  always_comb begin
    acc_sh = acc_d >>> FRAC;
    if (acc_sh[ACC_W-1]) begin
      sat = 8'd0;
    end else if (|acc_sh[ACC_W-2:7]) begin
      sat = 8'd127;
    end else begin
      sat = acc_sh[7:0];
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    if (state_d == OUT) begin
      out_data_d = sat;
      out_idx_d  = n_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= 8'd0;
      n_q         <= 8'd0;
      in_ready_q  <= 1'b0;
      bias_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= 8'd0;
      out_idx_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      n_q         <= n_d;
      in_ready_q  <= (state_d == ACC);
      bias_en_q   <= (state_d == BIAS_REQ);
      out_valid_q <= (state_d == OUT);
      done_q      <= (state_d == DONE);
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bias_en   = bias_en_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_structure1_fc1_acc.sv
// Directed bench for structure1_fc1_acc with default parameters.
// Inputs driven and outputs sampled on the falling edge.
module tb_structure1_fc1_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic       bias_en;
  logic [7:0] bias_in;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_idx;
  logic       done;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (in_valid && in_ready) hs_cnt = hs_cnt + 1;

  structure1_fc1_acc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias_en  (bias_en),
    .bias_in  (bias_in),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_idx  (out_idx),
    .done     (done)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    x_in = 8'd0;
    w_in = 8'd0;
    bias_in = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance until out_valid seen at a falling edge, or budget spent.
  task automatic wait_out(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, bias_en, out_valid, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000",
               {in_ready, bias_en, out_valid, done});
    end
    checks++;
    if ({out_data, out_idx} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0/0",
               out_data, out_idx);
    end
  endtask

  task automatic test_unity();
    int cyc;
    do_reset();
    x_in = 8'd1;
    w_in = 8'd1;
    in_valid = 1'b1;
    pulse_start();
    checks++;
    if (bias_en !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL cyc1: bias_en=%b in_ready=%b want 1/0",
               bias_en, in_ready);
    end
    @(negedge clk);
    checks++;
    if (bias_en !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL cyc2: bias_en=%b in_ready=%b want 0/0",
               bias_en, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cyc3: in_ready=%b want 1", in_ready);
    end
    cyc = 3;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 67) begin
      errors++;
      $display("FAIL unity_lat: cycle %0d want 67", cyc);
    end
    checks++;
    if (out_data !== 8'd4 || out_idx !== 8'd0) begin
      errors++;
      $display("FAIL unity_out: data=%0d idx=%0d want 4/0",
               out_data, out_idx);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || bias_en !== 1'b1) begin
      errors++;
      $display("FAIL unity_next: ov=%b be=%b want 0/1",
               out_valid, bias_en);
    end
    checks++;
    if (out_data !== 8'd4) begin
      errors++;
      $display("FAIL unity_hold: data=%0d want 4", out_data);
    end
  endtask

  task automatic test_bias();
    bit ok;
    do_reset();
    bias_in = 8'd16;
    in_valid = 1'b1;
    pulse_start();
    wait_out(200, ok);
    checks++;
    if (!ok || out_data !== 8'd16 || out_idx !== 8'd0) begin
      errors++;
      $display("FAIL bias_pos: ok=%0d data=%0d idx=%0d want 16/0",
               ok, out_data, out_idx);
    end
    bias_in = 8'hF0;
    wait_out(200, ok);
    checks++;
    if (!ok || out_data !== 8'd0 || out_idx !== 8'd1) begin
      errors++;
      $display("FAIL bias_neg: ok=%0d data=%0d idx=%0d want 0/1",
               ok, out_data, out_idx);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    x_in = 8'd127;
    w_in = 8'd127;
    in_valid = 1'b1;
    pulse_start();
    wait_out(200, ok);
    checks++;
    if (!ok || out_data !== 8'd127) begin
      errors++;
      $display("FAIL sat_hi: ok=%0d data=%0d want 127",
               ok, out_data);
    end
    x_in = 8'h80;
    wait_out(200, ok);
    checks++;
    if (!ok || out_data !== 8'd0 || out_idx !== 8'd1) begin
      errors++;
      $display("FAIL sat_lo: ok=%0d data=%0d idx=%0d want 0/1",
               ok, out_data, out_idx);
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    x_in = 8'd2;
    w_in = 8'd3;
    in_valid = 1'b1;
    hs_cnt = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (hs_cnt !== 0) begin
      errors++;
      $display("FAIL idle_consume: hs=%0d want 0", hs_cnt);
    end
    pulse_start();
    n = 0;
    while (!out_valid && n < 1000) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!out_valid || out_data !== 8'd24 || out_idx !== 8'd0) begin
      errors++;
      $display("FAIL stall_out: ov=%b data=%0d want 1/24",
               out_valid, out_data);
    end
    checks++;
    if (hs_cnt !== 64) begin
      errors++;
      $display("FAIL stall_hs: hs=%0d want 64", hs_cnt);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (hs_cnt !== 64 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: hs=%0d rdy=%b want 64/1",
               hs_cnt, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    do_reset();
    x_in = 8'd1;
    w_in = 8'd1;
    in_valid = 1'b1;
    pulse_start();
    n = 0;
    while (!(out_valid && out_idx == 8'd4) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_acc: in_ready=%b want 1", in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_idx !== 8'd0 ||
        out_valid !== 1'b0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst: rdy=%b idx=%0d data=%0d want 0/0/0",
               in_ready, out_idx, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_out(200, ok);
    checks++;
    if (!ok || out_idx !== 8'd0 || out_data !== 8'd4) begin
      errors++;
      $display("FAIL mid_restart: ok=%0d idx=%0d data=%0d want 0/4",
               ok, out_idx, out_data);
    end
  endtask

  task automatic test_full_frame();
    int be_cnt, ov_cnt, dn_cnt, dn_cyc, bad;
    logic [7:0] exp_idx;
    do_reset();
    x_in = 8'd1;
    w_in = 8'd1;
    in_valid = 1'b1;
    be_cnt = 0;
    ov_cnt = 0;
    dn_cnt = 0;
    dn_cyc = 0;
    bad = 0;
    exp_idx = 8'd0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 8620; cyc++) begin
      @(negedge clk);
      start = (cyc == 100);
      if (bias_en) be_cnt++;
      if (out_valid) begin
        if (out_idx !== exp_idx || out_data !== 8'd4) bad++;
        exp_idx = exp_idx + 8'd1;
        ov_cnt++;
      end
      if (done) begin
        dn_cnt++;
        dn_cyc = cyc;
      end
    end
    checks++;
    if (be_cnt !== 128) begin
      errors++;
      $display("FAIL frame_bias: %0d pulses want 128", be_cnt);
    end
    checks++;
    if (ov_cnt !== 128 || bad !== 0) begin
      errors++;
      $display("FAIL frame_out: %0d outs %0d bad want 128/0",
               ov_cnt, bad);
    end
    checks++;
    if (dn_cnt !== 1 || dn_cyc !== 8577) begin
      errors++;
      $display("FAIL frame_done: %0d at %0d want 1 at 8577",
               dn_cnt, dn_cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    x_in = 8'd0;
    w_in = 8'd0;
    bias_in = 8'd0;
    test_reset();
    test_unity();
    test_bias();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/structure1_fc1_acc.md
# structure1_fc1_acc

Fully-connected layer-1 neuron engine for structure 1. It streams signed 8-bit activation/weight pairs from the FC1 operand fetch and accumulates N_IN products per output neuron. Each neuron's bias comes from the FC1 bias ROM reader, requested by pulsing that block's `en`. The block then applies ReLU with requantization and emits one 8-bit result per neuron to the next stage.

## Interface
- N_IN, 64, products accumulated per neuron (1..256)
- N_OUT, 128, neurons per frame (1..256)
- FRAC, 4, fractional bits of activations, bias and output; products carry 2*FRAC
- ACC_W, 24, accumulator width; 16 + log2(N_IN) + 1 ≤ ACC_W
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready
- x_in  in  8  signed activation
- w_in  in  8  signed weight
- bias_en  out  1  one-cycle request to the bias ROM reader (drives its `en`)
- bias_in  in  8  signed bias, valid the cycle after bias_en
- out_valid  out  1  one-cycle result strobe, no backpressure
- out_data  out  8  result, 0..127
- out_idx  out  8  neuron index of out_data
- done  out  1  one-cycle end-of-frame pulse

## Operation
- States: IDLE, BIAS_REQ, BIAS_WAIT, ACC, OUT, DONE.
- IDLE:
  - start=1 → BIAS_REQ.
  - Neuron counter n=0.
- BIAS_REQ:
  - bias_en=1 for exactly one cycle → BIAS_WAIT.
- BIAS_WAIT:
  - acc ← sign_extend(bias_in) <<< FRAC.
  - Beat counter k=0.
  - → ACC.
- ACC:
  - in_ready=1.
  - Each handshake: acc ← acc + x_in*w_in (signed 16-bit product, sign-extended); k++.
  - Handshake with k=N_IN-1 → OUT.
  - in_valid=0 cycles leave acc and k unchanged.
- OUT:
  - out_valid=1, out_idx=n.
  - out_data = 0 if (acc>>>FRAC)<0; 127 if (acc>>>FRAC)>127; else its low 8 bits.
  - n=N_OUT-1 → DONE; otherwise n++ → BIAS_REQ.
- DONE:
  - done=1 → IDLE.
- Fetch and ReLU:
  - Exactly one bias_en pulse per neuron, N_OUT pulses per frame.
  - The bias reader advances its address on the falling edge of en, so neuron n reads bias address n.
  - That address returns to 0 only on rst_n, so back-to-back frames require N_OUT=256 (natural wrap) or a reset between frames.
- Inputs and overflow:
  - start outside IDLE is ignored.
  - in_ready=0 outside ACC; operands presented then are not consumed.
  - With ACC_W satisfying the width rule, acc cannot overflow. No wrap handling is needed.
- Reset:
  - rst_n low at any time, including mid-ACC, forces IDLE.
  - acc, k, n clear to 0; every output goes to 0.
  - Partial results are discarded.

## Timing
- Reset values: in_ready=0, bias_en=0, out_valid=0, out_data=0, out_idx=0, done=0.
- Relative to the start sample at cycle 0:
  - bias_en high in cycle 1.
  - bias_in captured in cycle 2.
  - in_ready high from cycle 3.
- out_valid is asserted the cycle after the N_IN-th handshake.
  - out_data and out_idx hold their values until the next out_valid.
- Next bias_en follows out_valid by 1 cycle.
- Per-neuron minimum: N_IN + 3 cycles.
- Full-throughput frame: N_OUT*(N_IN+3) + 1 cycles from start to done.
- done occurs 1 cycle after the last out_valid.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset → all outputs 0. Assert rst_n low mid-ACC of neuron 5 → IDLE next edge, in_ready=0. A new start then yields out_idx=0 first.
- Unity sum: bias_in=0, x=1, w=1 for 64 beats → out_data=4 (acc=64, >>>4), out_idx=0, out_valid for 1 cycle.
- Bias only: bias_in=16, x=0 → out_data=16. Then bias_in=-16, x=0 → out_data=0 (ReLU).
- Saturation and ReLU:
  - x=127, w=127 ×64 → out_data=127 (acc=1032256).
  - x=-128, w=127 ×64 → out_data=0.
  - No accumulator wrap in either case.
- Stalls: in_valid random 50%, x=2, w=3, bias=0 → out_data=24. Exactly 64 handshakes consumed; acc unchanged on idle cycles.
- Full frame with defaults:
  - Exactly 128 bias_en pulses and 128 out_valid with out_idx 0..127 in order, then a single done.
  - start pulsed during ACC is ignored.
  - Total 8577 cycles at full throughput.
